ram_read_streamer: RTL and testbench

RAM_READ_STREAMER -- requirements
Module: ram_read_streamer

---
 rtl/ram_read_streamer.sv | 80 ++++++++
 tb/tb_ram_read_streamer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_streamer.sv
// Streams single-word reads from a 1-cycle registered-read RAM into a 3-deep
// response FIFO, forwarding same-cycle writes so each read sees the RAM as of acceptance.
module ram_read_streamer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  ram_ren,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_wen,
    input  logic [ADDR_WIDTH-1:0] ram_waddr,
    input  logic [DATA_WIDTH-1:0] ram_din
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // req_ready depends only on registered occupancy (and reset); resp_valid only on FIFO count.
    logic                  in_flight;
    logic                  coll_flag;
    logic [DATA_WIDTH-1:0] coll_data;
    logic [DATA_WIDTH-1:0] fifo_mem [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            count;
    logic [2:0]            occupancy;
    logic                  accept;
    logic                  capture;
    logic                  pop;
    logic [DATA_WIDTH-1:0] capture_word;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign occupancy    = {2'b00, in_flight} + {1'b0, count};
    assign req_ready    = reset && (occupancy < 3'd3);
    assign accept       = req_valid && req_ready;
    assign capture      = in_flight;
    assign resp_valid   = (count != 2'd0);
    assign pop          = resp_valid && resp_ready;
    assign resp_data    = fifo_mem[rd_ptr];
    assign ram_ren      = accept;
    assign ram_raddr    = req_addr;
    assign capture_word = coll_flag ? coll_data : ram_dout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_flight <= 1'b0;
            coll_flag <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 2'd0;
        end else begin
            in_flight <= accept;
            // A write to the address being read wins over the RAM's pre-write value.
            coll_flag <= accept && ram_wen && (ram_waddr == req_addr);
            if (capture) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            case ({capture, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Data paths carry no reset; validity is tracked by the flags above.
    always_ff @(posedge clock) begin
        if (accept)  coll_data        <= ram_din;
        if (capture) fifo_mem[wr_ptr] <= capture_word;
    end

endmodule

// File: tb/tb_ram_read_streamer.sv
// Bench for ram_read_streamer: RAM model with registered read, reference queue of
// expected responses computed at acceptance time from a shadow memory.
module tb_ram_read_streamer;
    localparam int AW = 6;
    localparam int DW = 64;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout;
    logic          ram_wen;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_din;

    ram_read_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_din(ram_din)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 1-cycle registered-read RAM, read returns the pre-write contents
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clock) begin
        if (ram_ren) ram_dout <= ram[ram_raddr];
        if (ram_wen) ram[ram_waddr] <= ram_din;
    end

    // reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            acc_q [$];
    int            cyc;
    int            checks;
    int            errors;
    int            accepts;
    int            dut_pops;
    logic [DW-1:0] last_resp;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle();
        logic exp_ready;
        logic exp_valid;
        logic acc;
        logic pop;
        #1;
        exp_ready = (exp_q.size() < 3);
        exp_valid = (exp_q.size() > 0) && (acc_q[0] <= cyc - 2);
        check("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
        check("resp_valid", {63'd0, resp_valid}, {63'd0, exp_valid});
        acc = req_valid && exp_ready;
        check("ram_ren", {63'd0, ram_ren}, {63'd0, acc});
        if (acc) check("ram_raddr", {58'd0, ram_raddr}, {58'd0, req_addr});
        if (exp_valid) check("resp_data", resp_data, exp_q[0]);
        pop = exp_valid && resp_ready;
        if (req_valid && req_ready) accepts++;
        if (resp_valid && resp_ready) begin
            dut_pops++;
            last_resp = resp_data;
        end
        if (pop) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back((ram_wen && ram_waddr == req_addr) ? ram_din : ref_mem[req_addr]);
            acc_q.push_back(cyc);
        end
        if (ram_wen) ref_mem[ram_waddr] = ram_din;
        @(negedge clock);
        cyc++;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        ram_wen   = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic read_req(input logic [AW-1:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        checks = 0; errors = 0; accepts = 0; dut_pops = 0; cyc = 0;
        last_resp = '0;
        reset = 1'b0; req_valid = 1'b1; req_addr = '0; resp_ready = 1'b1;
        ram_wen = 1'b0; ram_waddr = '0; ram_din = '0;

        // reset state with a request offered
        @(negedge clock); #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_ram_ren", {63'd0, ram_ren}, 64'd0);
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        cycle();

        // preload RAM through its write port
        for (int i = 0; i < DEPTH; i++) begin
            ram_wen   = 1'b1;
            ram_waddr = AW'(i);
            if (i == 5)      ram_din = 64'hAA;
            else if (i < 5)  ram_din = DW'(i + 'h10);
            else if (i == 7) ram_din = 64'h11;
            else             ram_din = {$urandom, $urandom};
            cycle();
        end
        ram_wen = 1'b0;

        // single read, 2-cycle latency
        resp_ready = 1'b1;
        read_req(AW'(5));
        idle(4);
        check("single_data", last_resp, 64'hAA);

        // back-to-back reads at full throughput
        for (int i = 0; i < 5; i++) read_req(AW'(i));
        idle(4);
        check("b2b_last", last_resp, 64'h14);

        // backpressure: exactly three accepts
        resp_ready = 1'b0;
        accepts = 0;
        for (int i = 0; i < 6; i++) read_req(AW'($urandom_range(0, DEPTH - 1)));
        check("stall_accepts", DW'(accepts), 64'd3);
        resp_ready = 1'b1;
        idle(5);

        // write collision and later write
        req_valid = 1'b1; req_addr = AW'(7);
        ram_wen = 1'b1; ram_waddr = AW'(7); ram_din = 64'h55;
        cycle();
        req_valid = 1'b0; ram_din = 64'h66;
        cycle();
        idle(3);
        check("collision_data", last_resp, 64'h55);

        // reset with one in flight and two buffered
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) read_req(AW'($urandom_range(0, DEPTH - 1)));
        reset = 1'b0;
        #1;
        check("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("mid_rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("mid_rst_ram_ren", {63'd0, ram_ren}, 64'd0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clock);
        cyc++;
        reset = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        idle(4);

        // pointer wrap: seven reads with random stalls
        base = dut_pops;
        for (int i = 0; i < 7; i++) begin
            resp_ready = 1'($urandom_range(0, 1));
            read_req(AW'($urandom_range(0, DEPTH - 1)));
            req_valid = 1'b0;
            resp_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        resp_ready = 1'b1;
        idle(5);
        check("wrap_count", DW'(dut_pops - base), 64'd7);

        // random mixed traffic with collisions
        for (int i = 0; i < 400; i++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_addr   = AW'($urandom_range(0, DEPTH - 1));
            resp_ready = ($urandom_range(0, 3) != 0);
            ram_wen    = ($urandom_range(0, 2) == 0);
            ram_waddr  = ($urandom_range(0, 1) == 1) ? req_addr : AW'($urandom_range(0, DEPTH - 1));
            ram_din    = {$urandom, $urandom};
            cycle();
        end
        resp_ready = 1'b1;
        idle(6);
        check("final_empty", {63'd0, resp_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
